// File: rtl/matrix_load_ctrl_pkg.sv
// ============================================================================
//  matrix_load_ctrl_pkg
//  Shared types and defaults for the matrix datapath blocks.
//  Rev 1.0
// ============================================================================
`default_nettype none

package matrix_load_ctrl_pkg;

    localparam int c_default_size_a = 8;
    localparam int c_default_size_b = 8;
    localparam int c_default_width  = 22;

    typedef logic signed [c_default_width-1:0] mat_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

    // Index width for a dimension of n entries; a 1-entry dimension still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_load_ctrl_rc_counter.sv
// ============================================================================
//  rc_counter
//  Row-major row/column index counter with wrap and terminal-count flag.
//  Rev 1.0
// ============================================================================
`default_nettype none

module rc_counter
    import matrix_load_ctrl_pkg::*;
#(
    parameter int SIZE_A = c_default_size_a,
    parameter int SIZE_B = c_default_size_b,
    parameter int ROW_W  = idx_width(SIZE_A),
    parameter int COL_W  = idx_width(SIZE_B)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_last
);

    localparam logic [ROW_W-1:0] c_row_max = ROW_W'(SIZE_A - 1);
    localparam logic [COL_W-1:0] c_col_max = COL_W'(SIZE_B - 1);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_inc) begin
            if (r_col == c_col_max) begin
                r_col <= '0;
                // Wrapping the row after the final element keeps both indices in range.
                r_row <= (r_row == c_row_max) ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == c_row_max) && (r_col == c_col_max);

endmodule

`default_nettype wire

// File: rtl/matrix_load_ctrl.sv
// ============================================================================
//  matrix_load_ctrl
//  Loads a signed SIZE_A x SIZE_B matrix row-major from a valid/ready stream.
//  Rev 1.0
// ============================================================================
`default_nettype none

module matrix_load_ctrl
    import matrix_load_ctrl_pkg::*;
#(
    parameter int SIZE_A = c_default_size_a,
    parameter int SIZE_B = c_default_size_b,
    parameter int WIDTH  = c_default_width
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] out_matrix [SIZE_A][SIZE_B],
    output logic                    busy,
    output logic                    done,
    output logic                    matrix_valid,
    output logic                    start_err
);

    localparam int c_row_w = idx_width(SIZE_A);
    localparam int c_col_w = idx_width(SIZE_B);

    load_state_t        r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_matrix_valid;
    logic               r_start_err;

    logic               w_xfer;
    logic               w_clr;
    logic               w_last;
    logic [c_row_w-1:0] w_row;
    logic [c_col_w-1:0] w_col;

    assign in_ready = (r_state == LOAD);
    assign w_xfer   = in_valid && in_ready;
    assign w_clr    = (r_state == IDLE) && start;

    rc_counter #(
        .SIZE_A (SIZE_A),
        .SIZE_B (SIZE_B),
        .ROW_W  (c_row_w),
        .COL_W  (c_col_w)
    ) u_rc_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_inc  (w_xfer),
        .o_row  (w_row),
        .o_col  (w_col),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_matrix_valid <= 1'b0;
            r_start_err    <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state        <= LOAD;
                        r_busy         <= 1'b1;
                        r_matrix_valid <= 1'b0;
                    end
                end
                LOAD: begin
                    if (start) begin
                        r_start_err <= 1'b1;
                    end
                    if (w_xfer && w_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    // A start landing here is still treated as busy.
                    if (start) begin
                        r_start_err <= 1'b1;
                    end
                    r_state        <= IDLE;
                    r_busy         <= 1'b0;
                    r_matrix_valid <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign matrix_valid = r_matrix_valid;
    assign start_err    = r_start_err;

    // Storage keeps its contents across loads until each element is overwritten.
    for (genvar gr = 0; gr < SIZE_A; gr++) begin : g_row
        for (genvar gc = 0; gc < SIZE_B; gc++) begin : g_col
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_matrix[gr][gc] <= '0;
                end else if (w_xfer && (w_row == c_row_w'(gr)) && (w_col == c_col_w'(gc))) begin
                    out_matrix[gr][gc] <= in_data;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_matrix_load_ctrl.sv
// ============================================================================
//  tb_matrix_load_ctrl
//  Randomised self-checking bench against a row-major fill model.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_matrix_load_ctrl;

    localparam int SA = 2;
    localparam int SB = 3;
    localparam int W  = 22;
    localparam int N  = SA * SB;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] in_data = '0;
    logic                in_ready, busy, done, matrix_valid, start_err;
    logic signed [W-1:0] out_matrix [SA][SB];

    matrix_load_ctrl #(.SIZE_A(SA), .SIZE_B(SB), .WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_matrix   (out_matrix),
        .busy         (busy),
        .done         (done),
        .matrix_valid (matrix_valid),
        .start_err    (start_err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    logic signed [W-1:0] stim [N];

    // Reference model: phase 0 idle, 1 loading, 2 done; words counted in fill order.
    int                  m_phase;
    int                  m_cnt;
    bit                  m_busy, m_done, m_mv, m_err;
    logic signed [W-1:0] m_mat [SA][SB];

    int   cyc, ctl_bad, done_cyc, mv_cyc, busy_lo_cyc, err_cyc, err_cnt, last_xfer_cyc;
    logic mv_at1;

    task automatic model_reset();
        m_phase = 0; m_cnt = 0;
        m_busy = 0; m_done = 0; m_mv = 0; m_err = 0;
        for (int r = 0; r < SA; r++)
            for (int c = 0; c < SB; c++)
                m_mat[r][c] = '0;
    endtask

    task automatic tick();
        bit s, v;
        logic signed [W-1:0] d;
        @(posedge clk);
        s = start; v = in_valid; d = in_data;
        m_done = 0; m_err = 0;
        case (m_phase)
            0: if (s) begin m_phase = 1; m_cnt = 0; m_mv = 0; m_busy = 1; end
            1: begin
                if (s) m_err = 1;
                if (v) begin
                    m_mat[m_cnt / SB][m_cnt % SB] = d;
                    m_cnt++;
                    last_xfer_cyc = cyc;
                    if (m_cnt == N) begin m_phase = 2; m_done = 1; end
                end
            end
            default: begin
                if (s) m_err = 1;
                m_phase = 0; m_mv = 1; m_busy = 0;
            end
        endcase
        cyc++;
        @(negedge clk);
        if (done !== m_done || busy !== m_busy || matrix_valid !== m_mv ||
            start_err !== m_err || in_ready !== (m_phase == 1))
            ctl_bad++;
        if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        if (matrix_valid === 1'b1 && mv_cyc < 0) mv_cyc = cyc;
        if (busy === 1'b0 && busy_lo_cyc < 0) busy_lo_cyc = cyc;
        if (start_err === 1'b1) begin
            err_cnt++;
            if (err_cyc < 0) err_cyc = cyc;
        end
        if (cyc == 1) mv_at1 = matrix_valid;
    endtask

    // gap: 0 continuous, 1 every other cycle, 2 random. glitch_at: word index to pulse start on.
    task automatic drive_load(input int gap, input int glitch_at, input int stop_after, input int post);
        int k = 0;
        int b = 0;
        cyc = 0; ctl_bad = 0; done_cyc = -1; mv_cyc = -1; busy_lo_cyc = -1;
        err_cyc = -1; err_cnt = 0; last_xfer_cyc = -1; mv_at1 = 1'bx;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (k < stop_after && b < 200) begin
            case (gap)
                0:       in_valid = 1'b1;
                1:       in_valid = ((b % 2) == 0);
                default: in_valid = ($urandom_range(0, 1) == 1);
            endcase
            in_data = stim[k];
            start = (k == glitch_at) && in_valid;
            tick();
            if (in_valid) k++;
            start = 1'b0;
            in_valid = 1'b0;
            b++;
        end
        in_data = '0;
        repeat (post) tick();
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) stim[i] = W'($urandom);
    endtask

    task automatic test_reset();
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if ({in_ready, busy, done, matrix_valid, start_err} !== 5'b0) begin
            nerr++;
            $display("FAIL reset_ctrl: got %b required 00000", {in_ready, busy, done, matrix_valid, start_err});
        end
        for (int r = 0; r < SA; r++)
            for (int c = 0; c < SB; c++) begin
                nvec++;
                if (out_matrix[r][c] !== '0) begin
                    nerr++;
                    $display("FAIL reset_mat[%0d][%0d]: got %0d required 0", r, c, out_matrix[r][c]);
                end
            end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_continuous();
        for (int i = 0; i < N; i++) stim[i] = W'(i + 1);
        drive_load(0, -1, N, 2);
        nvec++;
        if (ctl_bad !== 0) begin nerr++; $display("FAIL cont_ctrl: bad cycles %0d required 0", ctl_bad); end
        nvec++;
        if (done_cyc !== 7) begin nerr++; $display("FAIL cont_done_cyc: got %0d required 7", done_cyc); end
        nvec++;
        if (mv_cyc !== 8) begin nerr++; $display("FAIL cont_mv_cyc: got %0d required 8", mv_cyc); end
        nvec++;
        if (busy_lo_cyc !== 8) begin nerr++; $display("FAIL cont_busy_lo: got %0d required 8", busy_lo_cyc); end
        for (int r = 0; r < SA; r++)
            for (int c = 0; c < SB; c++) begin
                nvec++;
                if (int'(out_matrix[r][c]) !== r * SB + c + 1) begin
                    nerr++;
                    $display("FAIL cont_mat[%0d][%0d]: got %0d required %0d", r, c, out_matrix[r][c], r * SB + c + 1);
                end
            end
    endtask

    task automatic test_gaps();
        fill_random();
        drive_load(1, -1, N, 2);
        nvec++;
        if (ctl_bad !== 0) begin nerr++; $display("FAIL gap_ctrl: bad cycles %0d required 0", ctl_bad); end
        nvec++;
        if (done_cyc !== 12) begin nerr++; $display("FAIL gap_done_cyc: got %0d required 12", done_cyc); end
        nvec++;
        if (done_cyc !== last_xfer_cyc + 1) begin
            nerr++; $display("FAIL gap_done_lat: got %0d required %0d", done_cyc, last_xfer_cyc + 1);
        end
        for (int r = 0; r < SA; r++)
            for (int c = 0; c < SB; c++) begin
                nvec++;
                if (out_matrix[r][c] !== stim[r * SB + c]) begin
                    nerr++;
                    $display("FAIL gap_mat[%0d][%0d]: got %0d required %0d", r, c, out_matrix[r][c], stim[r * SB + c]);
                end
            end
    endtask

    task automatic test_full_scale();
        int exp_v;
        for (int i = 0; i < N; i++) stim[i] = (i % 2 == 0) ? 22'sh200000 : 22'sh1FFFFF;
        drive_load(0, -1, N, 2);
        for (int r = 0; r < SA; r++)
            for (int c = 0; c < SB; c++) begin
                exp_v = ((r * SB + c) % 2 == 0) ? -2097152 : 2097151;
                nvec++;
                if (int'(out_matrix[r][c]) !== exp_v) begin
                    nerr++;
                    $display("FAIL fs_mat[%0d][%0d]: got %0d required %0d", r, c, out_matrix[r][c], exp_v);
                end
            end
    endtask

    task automatic test_start_while_busy();
        fill_random();
        drive_load(0, 2, N, 0);
        nvec++;
        if (err_cnt !== 1 || err_cyc !== 4) begin
            nerr++; $display("FAIL busy_err: count %0d cycle %0d required 1 at 4", err_cnt, err_cyc);
        end
        // Now sitting in the DONE cycle: a start here must also be rejected.
        start = 1'b1;
        tick();
        start = 1'b0;
        nvec++;
        if (start_err !== 1'b1 || busy !== 1'b0 || matrix_valid !== 1'b1) begin
            nerr++;
            $display("FAIL done_start: err %b busy %b mv %b required 1 0 1", start_err, busy, matrix_valid);
        end
        tick();
        nvec++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || start_err !== 1'b0) begin
            nerr++; $display("FAIL done_start_ignored: busy %b ready %b err %b required 0 0 0", busy, in_ready, start_err);
        end
        nvec++;
        if (ctl_bad !== 0) begin nerr++; $display("FAIL busy_ctrl: bad cycles %0d required 0", ctl_bad); end
        for (int r = 0; r < SA; r++)
            for (int c = 0; c < SB; c++) begin
                nvec++;
                if (out_matrix[r][c] !== stim[r * SB + c]) begin
                    nerr++;
                    $display("FAIL busy_mat[%0d][%0d]: got %0d required %0d", r, c, out_matrix[r][c], stim[r * SB + c]);
                end
            end
    endtask

    task automatic test_reset_midload();
        bit any_set;
        fill_random();
        drive_load(0, -1, 4, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        any_set = (in_ready !== 1'b0) || (busy !== 1'b0) || (done !== 1'b0) ||
                  (matrix_valid !== 1'b0) || (start_err !== 1'b0);
        for (int r = 0; r < SA; r++)
            for (int c = 0; c < SB; c++)
                if (out_matrix[r][c] !== '0) any_set = 1;
        nvec++;
        if (any_set) begin
            nerr++; $display("FAIL midload_reset: outputs nonzero %b required 0", any_set);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fill_random();
        drive_load(0, -1, N, 2);
        nvec++;
        if (ctl_bad !== 0) begin nerr++; $display("FAIL reload_ctrl: bad cycles %0d required 0", ctl_bad); end
        nvec++;
        if (mv_cyc !== done_cyc + 1 || done_cyc !== 7) begin
            nerr++; $display("FAIL reload_mv: mv %0d done %0d required 8 7", mv_cyc, done_cyc);
        end
        for (int r = 0; r < SA; r++)
            for (int c = 0; c < SB; c++) begin
                nvec++;
                if (out_matrix[r][c] !== stim[r * SB + c]) begin
                    nerr++;
                    $display("FAIL reload_mat[%0d][%0d]: got %0d required %0d", r, c, out_matrix[r][c], stim[r * SB + c]);
                end
            end
    endtask

    task automatic test_back_to_back();
        fill_random();
        drive_load(0, -1, N, 2);
        for (int i = 0; i < N; i++) stim[i] = ~stim[i];
        drive_load(0, -1, N, 2);
        nvec++;
        if (mv_at1 !== 1'b0) begin nerr++; $display("FAIL b2b_mv_fall: got %b required 0", mv_at1); end
        nvec++;
        if (ctl_bad !== 0) begin nerr++; $display("FAIL b2b_ctrl: bad cycles %0d required 0", ctl_bad); end
        for (int r = 0; r < SA; r++)
            for (int c = 0; c < SB; c++) begin
                nvec++;
                if (out_matrix[r][c] !== stim[r * SB + c]) begin
                    nerr++;
                    $display("FAIL b2b_mat[%0d][%0d]: got %0d required %0d", r, c, out_matrix[r][c], stim[r * SB + c]);
                end
            end
    endtask

    task automatic test_random_gaps();
        for (int it = 0; it < 4; it++) begin
            fill_random();
            drive_load(2, -1, N, 2);
            nvec++;
            if (ctl_bad !== 0 || done_cyc !== last_xfer_cyc + 1) begin
                nerr++;
                $display("FAIL rnd_ctrl[%0d]: bad %0d done %0d required 0 %0d", it, ctl_bad, done_cyc, last_xfer_cyc + 1);
            end
            for (int r = 0; r < SA; r++)
                for (int c = 0; c < SB; c++) begin
                    nvec++;
                    if (out_matrix[r][c] !== m_mat[r][c]) begin
                        nerr++;
                        $display("FAIL rnd_mat[%0d][%0d]: got %0d required %0d", r, c, out_matrix[r][c], m_mat[r][c]);
                    end
                end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_full_scale();
        test_start_while_busy();
        test_reset_midload();
        test_back_to_back();
        test_random_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
